// File: rtl/facto_host_seq_pkg.sv
// Shared definitions for the factorial host sequencer.
// - Default register offsets of the factorial core's slave port. The core's
//   register controller uses the same offsets.
// - 4-bit FSM state encoding.
package facto_host_seq_pkg;

  localparam logic [15:0] REG_OS  = 16'h0000;  // opstart, write 1 = start
  localparam logic [15:0] REG_OC  = 16'h0008;  // opclear, write 1 = clear
  localparam logic [15:0] REG_OI  = 16'h0010;  // interrupt enable
  localparam logic [15:0] REG_OPR = 16'h0018;  // operand
  localparam logic [15:0] REG_OD  = 16'h0020;  // opdone, bit0 = done
  localparam logic [15:0] REG_RH  = 16'h0028;  // result high word
  localparam logic [15:0] REG_RL  = 16'h0030;  // result low word

  localparam int unsigned TIMEOUT_DEF = 1024;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_CLR  = 4'd1,
    ST_IEN  = 4'd2,
    ST_OPW  = 4'd3,
    ST_STW  = 4'd4,
    ST_WAIT = 4'd5,
    ST_RDH  = 4'd6,
    ST_RDL  = 4'd7,
    ST_CLR2 = 4'd8,
    ST_ABT  = 4'd9,
    ST_RSP  = 4'd10
  } state_t;

endpackage

// File: rtl/facto_host_seq_wdog.sv
// facto_wdog: WAIT-phase timeout and poll counter.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clr            hold the counter at 0
//   en             count one cycle (WAIT state)
//   expired        counter has reached TIMEOUT-1 while enabled
//   poll_tick      every 4th enabled cycle (count = 3, 7, 11, ...)
module facto_wdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired,
  output logic poll_tick
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    expired   = en && (cnt == LAST);
    poll_tick = en && (cnt[1:0] == 2'b11);
  end

endmodule

// File: rtl/facto_host_seq.sv
// facto_host_seq: bus-master sequencer in front of the factorial core.
// Accepts an operand on req_*, programs the core over m_* (clear, interrupt
// enable, operand, start), waits for done, reads the 128-bit result and
// returns it on rsp_*. A WAIT longer than TIMEOUT cycles aborts with rsp_err.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_operand   operand request (ready only in IDLE)
//   rsp_valid/rsp_ready               response handshake, held until accepted
//   rsp_result, rsp_err               {RH,RL} result; err = timeout (result 0)
//   m_sel/m_wr/m_addr/m_dout/m_din    single-cycle register bus to the core
//   intr_in                           core done interrupt
//   busy                              high outside IDLE
// Build option: FACTO_POLL_EN -- interrupt disabled, WAIT polls opdone
// every 4th cycle instead of watching intr_in.
module facto_host_seq
  import facto_host_seq_pkg::*;
#(
  parameter logic [15:0] A_OS    = REG_OS,
  parameter logic [15:0] A_OC    = REG_OC,
  parameter logic [15:0] A_OI    = REG_OI,
  parameter logic [15:0] A_OPR   = REG_OPR,
  parameter logic [15:0] A_OD    = REG_OD,
  parameter logic [15:0] A_RH    = REG_RH,
  parameter logic [15:0] A_RL    = REG_RL,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [63:0]  req_operand,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_result,
  output logic         rsp_err,
  output logic         m_sel,
  output logic         m_wr,
  output logic [15:0]  m_addr,
  output logic [63:0]  m_dout,
  input  logic [63:0]  m_din,
  input  logic         intr_in,
  output logic         busy
);

`ifdef FACTO_POLL_EN
  localparam logic [63:0] IEN_VAL = 64'd0;
`else
  localparam logic [63:0] IEN_VAL = 64'd1;
`endif

  state_t        state, state_nxt;
  logic [63:0]   operand;
  logic [127:0]  result;
  logic          err;
  logic          done;
  logic          expired;
  logic          poll_tick;

  facto_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (state != ST_WAIT),
    .en        (state == ST_WAIT),
    .expired   (expired),
    .poll_tick (poll_tick)
  );

`ifdef FACTO_POLL_EN
  logic unused_intr;
  assign unused_intr = intr_in;
`else
  logic        unused_poll;
  logic [15:0] unused_od;
  assign unused_poll = poll_tick;
  assign unused_od   = A_OD;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m_sel     = 1'b0;
    m_wr      = 1'b0;
    m_addr    = '0;
    m_dout    = '0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) state_nxt = ST_CLR;
      end
      ST_CLR: begin
        m_sel = 1'b1; m_wr = 1'b1; m_addr = A_OC; m_dout = 64'd1;
        state_nxt = ST_IEN;
      end
      ST_IEN: begin
        m_sel = 1'b1; m_wr = 1'b1; m_addr = A_OI; m_dout = IEN_VAL;
        state_nxt = ST_OPW;
      end
      ST_OPW: begin
        m_sel = 1'b1; m_wr = 1'b1; m_addr = A_OPR; m_dout = operand;
        state_nxt = ST_STW;
      end
      ST_STW: begin
        m_sel = 1'b1; m_wr = 1'b1; m_addr = A_OS; m_dout = 64'd1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
`ifdef FACTO_POLL_EN
        if (poll_tick) begin
          m_sel  = 1'b1;
          m_addr = A_OD;
          done   = m_din[0];
        end
`else
        done = intr_in;
`endif
        // done is tested first so it wins over a simultaneous expiry
        if (done) begin
          state_nxt = ST_RDH;
        end else if (expired) begin
          state_nxt = ST_ABT;
        end
      end
      ST_RDH: begin
        m_sel = 1'b1; m_addr = A_RH;
        state_nxt = ST_RDL;
      end
      ST_RDL: begin
        m_sel = 1'b1; m_addr = A_RL;
        state_nxt = ST_CLR2;
      end
      ST_CLR2, ST_ABT: begin
        m_sel = 1'b1; m_wr = 1'b1; m_addr = A_OC; m_dout = 64'd1;
        state_nxt = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operand <= '0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            operand <= req_operand;
            result  <= '0;
            err     <= 1'b0;
          end
        end
        ST_RDH:  result[127:64] <= m_din;
        ST_RDL:  result[63:0]   <= m_din;
        ST_ABT: begin
          result <= '0;
          err    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    rsp_valid  = (state == ST_RSP);
    rsp_result = result;
    rsp_err    = err;
  end

endmodule

// File: tb/tb_facto_host_seq.sv
// Bench for facto_host_seq: a behavioural factorial core answers the bus,
// transactions are compared against n! computed directly and against the
// expected register access order.
module tb_facto_host_seq;
  import facto_host_seq_pkg::*;

  localparam int unsigned TO = 32;

`ifdef FACTO_POLL_EN
  localparam logic [63:0] EXP_IEN = 64'd0;
`else
  localparam logic [63:0] EXP_IEN = 64'd1;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_operand;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_result;
  logic         rsp_err;
  logic         m_sel;
  logic         m_wr;
  logic [15:0]  m_addr;
  logic [63:0]  m_dout;
  logic [63:0]  m_din;
  logic         intr_in;
  logic         busy;

  always #5 clk = ~clk;

  facto_host_seq #(
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_operand (req_operand),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err),
    .m_sel       (m_sel),
    .m_wr        (m_wr),
    .m_addr      (m_addr),
    .m_dout      (m_dout),
    .m_din       (m_din),
    .intr_in     (intr_in),
    .busy        (busy)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] p;
    p = 128'd1;
    for (longint unsigned i = 2; i <= n; i++) p = p * 128'(i);
    return p;
  endfunction

  // behavioural core
  logic         core_ie    = 1'b0;
  logic         core_done  = 1'b0;
  logic [127:0] core_fact  = '0;
  int           core_cnt   = -1;
  int           core_delay = 1;

  assign intr_in = core_done & core_ie;

  always_comb begin
    m_din = '0;
    case (m_addr)
      REG_RH: m_din = core_fact[127:64];
      REG_RL: m_din = core_fact[63:0];
      REG_OD: m_din = {63'd0, core_done};
      default: m_din = '0;
    endcase
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] dout;
  } acc_t;

  acc_t log_q[$];
  int   polls = 0;
  int   cyc = 0;
  int   last_poll = -1;

  always @(negedge clk) begin
    cyc++;
    if (core_cnt > 0) core_cnt--;
    if (core_cnt == 0) begin
      core_done = 1'b1;
      core_cnt  = -1;
    end
    if (reset_n && m_sel) begin
      if (!m_wr && m_addr == REG_OD) begin
        polls++;
        if (last_poll >= 0) check("poll_gap", 128'(cyc - last_poll), 128'd4);
        last_poll = cyc;
      end else begin
        log_q.push_back('{m_wr, m_addr, m_dout});
      end
      if (m_wr) begin
        case (m_addr)
          REG_OC:  if (m_dout[0]) begin core_done = 1'b0; core_cnt = -1; end
          REG_OI:  core_ie = m_dout[0];
          REG_OPR: core_fact = fact(m_dout);
          REG_OS:  if (m_dout[0]) begin core_cnt = core_delay; last_poll = -1; end
          default: ;
        endcase
      end
    end else if (reset_n) begin
      check("bus_idle", 128'({m_wr, m_addr, m_dout}), 128'd0);
    end
  end

  // delay < 0: the core never finishes
  task automatic run_txn(input logic [63:0] n, input int delay, input int hold);
    logic [127:0] exp_res;
    logic         exp_err;
    logic [127:0] held_res;
    logic         held_err;
    acc_t         exp_q[$];
    int           k;
    exp_err = (delay < 0);
    exp_res = exp_err ? 128'd0 : fact(n);

    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    check("req_ready_idle", 128'(req_ready), 128'd1);

    core_delay = delay;
    log_q.delete();
    polls = 0;
    req_valid   = 1'b1;
    req_operand = n;
    @(negedge clk);
    req_valid   = 1'b0;
    req_operand = {$urandom, $urandom};
    check("busy_after_accept", 128'({busy, req_ready}), 128'b10);

    k = 0;
    while (!rsp_valid && k < int'(TO) + 100) begin @(negedge clk); k++; end
    check("rsp_valid_arrives", 128'(rsp_valid), 128'd1);

    held_res = rsp_result;
    held_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_state", 128'({rsp_valid, req_ready, rsp_err}), 128'({1'b1, 1'b0, held_err}));
      check("hold_result", rsp_result, held_res);
    end
    check("rsp_result", rsp_result, exp_res);
    check("rsp_err", 128'(rsp_err), 128'(exp_err));

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("after_handshake", 128'({rsp_valid, req_ready, busy}), 128'b010);

    exp_q.push_back('{1'b1, REG_OC, 64'd1});
    exp_q.push_back('{1'b1, REG_OI, EXP_IEN});
    exp_q.push_back('{1'b1, REG_OPR, n});
    exp_q.push_back('{1'b1, REG_OS, 64'd1});
    if (!exp_err) begin
      exp_q.push_back('{1'b0, REG_RH, 64'd0});
      exp_q.push_back('{1'b0, REG_RL, 64'd0});
    end
    exp_q.push_back('{1'b1, REG_OC, 64'd1});
    check("bus_count", 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check("bus_access", 128'({log_q[i].wr, log_q[i].addr, log_q[i].dout}),
            128'({exp_q[i].wr, exp_q[i].addr, exp_q[i].dout}));
    end
`ifdef FACTO_POLL_EN
    check("polls_seen", 128'(polls > 0), 128'd1);
`endif
  endtask

  initial begin
    logic quiet;
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_operand = '0;
    rsp_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          128'({req_ready, rsp_valid, rsp_err, m_sel, m_wr, busy, m_addr, m_dout}), 128'd1 << 85);
    check("reset_result", rsp_result, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_txn(64'd5, 20, 0);
    run_txn(64'd0, 5, 0);
    run_txn(64'd20, 7, 10);
    check("fact20_const", rsp_result, 128'h21C3677C82B40000);
    run_txn(64'd1, 3, 0);
    run_txn(64'd35, 2, 1);
    run_txn(64'd7, -1, 2);

    // reset while the core is computing
    core_delay = 20;
    req_valid = 1'b1; req_operand = 64'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("in_wait_busy", 128'(busy), 128'd1);
    reset_n = 1'b0;
    #1;
    check("midreset_outputs",
          128'({req_ready, rsp_valid, rsp_err, m_sel, m_wr, busy, m_addr, m_dout}), 128'd1 << 85);
    check("midreset_result", rsp_result, 128'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || busy) quiet = 1'b0;
    end
    check("no_rsp_after_reset", 128'(quiet), 128'd1);
    run_txn(64'd3, 4, 0);

    for (int t = 0; t < 12; t++) begin
      run_txn(64'($urandom_range(0, 60)), int'($urandom_range(1, 20)), int'($urandom_range(0, 3)));
    end
    run_txn(64'($urandom_range(0, 60)), -1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
